up_counter_timer_ctrl: RTL and testbench

Sequencing controller around a `bits`-wide up counter. It turns the free-running counter into a start/stop programmable timer with one-shot and periodic modes. The block latches a terminal value, enables counting, detects terminal count and reports it with single-cycle `tick`/`done` pulses. Upstream control logic uses it wherever a counted delay or periodic strobe is needed.

---
 rtl/up_counter_timer_ctrl.sv | 128 ++++++++++++
 tb/tb_up_counter_timer_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/up_counter_timer_ctrl.sv
// Start/stop programmable timer around a bits-wide up counter, one-shot or periodic.
// Define PRESCALER_EN to add the pre_div port and a clock-enable prescaler.
module up_counter_timer_ctrl #(
    parameter int bits     = 4,
    parameter int PRE_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                periodic,
    input  logic [bits-1:0]     period,
`ifdef PRESCALER_EN
    input  logic [PRE_BITS-1:0] pre_div,
`endif
    output logic [bits-1:0]     Q,
    output logic                busy,
    output logic                tick,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    logic [bits-1:0]     per_q;
    logic                mode_q;
    logic [PRE_BITS-1:0] div_q;
    logic [PRE_BITS-1:0] div_lim;
    logic                ce;
    logic                accept;

    // stop beats start, and a zero period is never a legal run
    assign accept = start && !stop && (period != '0);

`ifdef PRESCALER_EN
    logic [PRE_BITS-1:0] pre_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else if (state == IDLE && accept) begin
            pre_q <= pre_div;
        end
    end

    assign div_lim = pre_q;
`else
    // With a zero limit the divider never leaves 0, so ce is high every clock.
    assign div_lim = '0;
`endif

    assign ce = (div_q == div_lim);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            Q      <= '0;
            busy   <= 1'b0;
            tick   <= 1'b0;
            done   <= 1'b0;
            per_q  <= '0;
            mode_q <= 1'b0;
            div_q  <= '0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    Q     <= '0;
                    div_q <= '0;
                    if (accept) begin
                        per_q  <= period;
                        mode_q <= periodic;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    if (stop) begin
                        Q     <= '0;
                        div_q <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        div_q <= ce ? '0 : div_q + 1'b1;
                        if (ce) begin
                            if (Q != per_q) begin
                                Q <= Q + 1'b1;
                            end else begin
                                tick <= 1'b1;
                                if (mode_q) begin
                                    Q <= '0;
                                end else begin
                                    // one-shot: Q holds the period through DONE
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= DONE;
                                end
                            end
                        end
                    end
                end

                DONE: begin
                    Q     <= '0;
                    div_q <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    Q     <= '0;
                    div_q <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_counter_timer_ctrl.sv
// Scoreboard bench for up_counter_timer_ctrl (default build): the driver pushes
// model predictions per edge, a monitor pops and compares after each rising edge.
module tb_up_counter_timer_ctrl;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       periodic = 1'b0;
    logic [3:0] period   = '0;
    logic [3:0] Q;
    logic       busy;
    logic       tick;
    logic       done;

    up_counter_timer_ctrl #(.bits(4), .PRE_BITS(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .periodic(periodic),
        .period  (period),
        .Q       (Q),
        .busy    (busy),
        .tick    (tick),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] q;
        logic       busy;
        logic       tick;
        logic       done;
    } resp_t;

    typedef struct {
        resp_t r;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: a run is described only by its start-relative edge count.
    bit m_active = 0;
    bit m_mode   = 0;
    int m_per    = 0;
    int m_e      = 0;

    task automatic check(input string name, input resp_t act, input resp_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got q=%0d busy=%b tick=%b done=%b, expected q=%0d busy=%b tick=%b done=%b",
                     name, act.q, act.busy, act.tick, act.done, exp.q, exp.busy, exp.tick, exp.done);
        end
    endtask

    function automatic resp_t model_out();
        resp_t r = '0;
        if (m_active) begin
            if (m_mode) begin
                r.q    = 4'(m_e % (m_per + 1));
                r.busy = 1'b1;
                r.tick = (m_e > 0) && (m_e % (m_per + 1) == 0);
            end else if (m_e <= m_per) begin
                r.q    = 4'(m_e);
                r.busy = 1'b1;
            end else begin
                r.q    = 4'(m_per);
                r.tick = 1'b1;
                r.done = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic drive(input logic rs, input logic st, input logic sp, input logic md,
                         input logic [3:0] per, input string tag);
        exp_t e;
        @(negedge clk);
        reset    = rs;
        start    = st;
        stop     = sp;
        periodic = md;
        period   = per;
        if (rs) begin
            m_active = 0;
        end else if (m_active) begin
            if (!m_mode && m_e == m_per + 1) m_active = 0;  // the completion cycle ends the run
            else if (sp)                     m_active = 0;
            else                             m_e++;
        end else if (st && !sp && per != 0) begin
            m_active = 1;
            m_e      = 0;
            m_mode   = md;
            m_per    = int'(per);
        end
        e.r   = model_out();
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, periodic, period, tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, resp_t'({Q, busy, tick, done}), e.r);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "reset_hold");
        idle(2, "after_reset");

        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, "oneshot_start");
        idle(9, "oneshot_run");

        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd15, "periodic_start");
        idle(55, "periodic_run");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, "periodic_stop_q7");
        idle(3, "after_stop");

        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, "stop_term_p_start");
        idle(4, "stop_term_p_run");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, "stop_at_terminal_p");
        idle(2, "after_stop_term_p");

        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, "stop_term_o_start");
        idle(3, "stop_term_o_run");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, "stop_at_terminal_o");
        idle(2, "after_stop_term_o");

        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "start_period0");
        idle(2, "after_period0");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd6, "start_and_stop");
        idle(2, "after_start_stop");

        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd8, "latch_start");
        for (int i = 0; i < 9; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), "restart_ignored");
        idle(3, "latch_end");

        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd10, "midreset_start");
        idle(3, "midreset_run");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd10, "midreset_assert");
        #1;
        check("async_reset_immediate", resp_t'({Q, busy, tick, done}), '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "midreset_hold");
        idle(2, "midreset_release");

        for (int i = 0; i < 3000; i++)
            drive(1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "random");
        idle(2, "drain");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected responses never compared, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
